// File: rtl/mmio_bus_arbiter_if.sv
// Signal bundle between the two core requesters, the arbiter and the shared MMIO memory port.
// master: the arbiter's view (it serves the requesters and masters the memory port).
// slave : the surrounding system's view (requesters plus memory).
interface mmio_bus_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   localparam int MASK_W = DATA_W / 8;

   // requester 0: instruction fetch
   logic [ADDR_W-1:0] m0_addr;
   logic              m0_ren;
   logic              m0_wen;
   logic [DATA_W-1:0] m0_wdata;
   logic [MASK_W-1:0] m0_wmask;
   logic [DATA_W-1:0] m0_rdata;
   logic              m0_stall;

   // requester 1: load/store unit
   logic [ADDR_W-1:0] m1_addr;
   logic              m1_ren;
   logic              m1_wen;
   logic [DATA_W-1:0] m1_wdata;
   logic [MASK_W-1:0] m1_wmask;
   logic [DATA_W-1:0] m1_rdata;
   logic              m1_stall;

   // shared memory port
   logic [ADDR_W-1:0] s_waddr;
   logic [ADDR_W-1:0] s_raddr;
   logic              s_ren;
   logic              s_wen;
   logic [DATA_W-1:0] s_wdata;
   logic [MASK_W-1:0] s_wmask;
   logic [DATA_W-1:0] s_rdata;
   logic              s_rvalid;
   logic              s_wvalid;

   // status
   logic [1:0]        grant;
   logic              bus_err;

   modport master (
      input  m0_addr, m0_ren, m0_wen, m0_wdata, m0_wmask,
      output m0_rdata, m0_stall,
      input  m1_addr, m1_ren, m1_wen, m1_wdata, m1_wmask,
      output m1_rdata, m1_stall,
      output s_waddr, s_raddr, s_ren, s_wen, s_wdata, s_wmask,
      input  s_rdata, s_rvalid, s_wvalid,
      output grant, bus_err
   );

   modport slave (
      output m0_addr, m0_ren, m0_wen, m0_wdata, m0_wmask,
      input  m0_rdata, m0_stall,
      output m1_addr, m1_ren, m1_wen, m1_wdata, m1_wmask,
      input  m1_rdata, m1_stall,
      input  s_waddr, s_raddr, s_ren, s_wen, s_wdata, s_wmask,
      output s_rdata, s_rvalid, s_wvalid,
      input  grant, bus_err
   );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// Round-robin arbiter sharing one MMIO memory port between instruction fetch (m0) and
// load/store (m1). The winning request is latched and held until the slave completes it
// or the watchdog aborts it; each access is IDLE -> BUSY -> DONE.
module mmio_bus_arbiter #(
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 64,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rstn,
   mmio_bus_arbiter_if.master  bus
);
   localparam int          MASK_W = DATA_W / 8;
   localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYC);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_rr_ptr;
   logic              r_owner;
   logic              r_op_wr;
   logic              r_bus_err;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [MASK_W-1:0] r_wmask;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;
   logic [15:0]       r_wdog;

   logic              w_req0;
   logic              w_req1;
   logic              w_any_req;
   logic              w_winner;
   logic              w_complete;
   logic              w_wdog_hit;
   logic              w_timeout;
   logic              w_done0;
   logic              w_done1;
   logic              w_win_wr;
   logic [ADDR_W-1:0] w_win_addr;
   logic [DATA_W-1:0] w_win_wdata;
   logic [MASK_W-1:0] w_win_wmask;

   assign w_req0    = bus.m0_ren | bus.m0_wen;
   assign w_req1    = bus.m1_ren | bus.m1_wen;
   assign w_any_req = w_req0 | w_req1;
   // Contention goes to the round-robin pointer; otherwise the lone requester wins.
   assign w_winner  = (w_req0 & w_req1) ? r_rr_ptr : w_req1;

   assign w_win_wr    = w_winner ? bus.m1_wen   : bus.m0_wen;
   assign w_win_addr  = w_winner ? bus.m1_addr  : bus.m0_addr;
   assign w_win_wdata = w_winner ? bus.m1_wdata : bus.m0_wdata;
   assign w_win_wmask = w_winner ? bus.m1_wmask : bus.m0_wmask;

   // Only the valid matching the latched op completes it; the other is ignored.
   assign w_complete = r_op_wr ? bus.s_wvalid : bus.s_rvalid;
   assign w_wdog_hit = (TO_LIM != '0) && (({16'd0, r_wdog} + 32'd1) >= TO_LIM);
   assign w_timeout  = (r_state == BUSY) && !w_complete && w_wdog_hit;

   assign bus.s_waddr  = r_addr;
   assign bus.s_raddr  = r_addr;
   assign bus.s_wdata  = r_wdata;
   assign bus.s_wmask  = r_wmask;
   assign bus.m0_rdata = r_rdata0;
   assign bus.m1_rdata = r_rdata1;
   assign bus.bus_err  = r_bus_err;

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_any_req) w_state_nxt = BUSY;
         BUSY:    if (w_complete || w_timeout) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state: strobes, grant, per-requester done and stall
   always_comb begin
      bus.s_ren = 1'b0;
      bus.s_wen = 1'b0;
      bus.grant = '0;
      w_done0   = 1'b0;
      w_done1   = 1'b0;
      if (r_state == BUSY) begin
         bus.s_ren = ~r_op_wr;
         bus.s_wen = r_op_wr;
      end
      if (r_state != IDLE) bus.grant = r_owner ? 2'b10 : 2'b01;
      if (r_state == DONE) begin
         w_done0 = ~r_owner;
         w_done1 = r_owner;
      end
      bus.m0_stall = w_req0 & ~w_done0;
      bus.m1_stall = w_req1 & ~w_done1;
   end

   // Request latch, round-robin pointer, read-data capture, watchdog and error pulse
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rr_ptr  <= 1'b0;
         r_owner   <= 1'b0;
         r_op_wr   <= 1'b0;
         r_bus_err <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wmask   <= '0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
         r_wdog    <= '0;
      end else begin
         r_bus_err <= 1'b0;
         if (r_state == IDLE && w_any_req) begin
            r_owner  <= w_winner;
            r_rr_ptr <= ~w_winner;
            r_op_wr  <= w_win_wr;
            r_addr   <= w_win_addr;
            r_wdata  <= w_win_wdata;
            r_wmask  <= w_win_wmask;
         end
         // Writes and aborts both return zero read data to the owner.
         if (r_state == BUSY && (w_complete || w_timeout)) begin
            if (r_owner) r_rdata1 <= (w_complete && !r_op_wr) ? bus.s_rdata : '0;
            else         r_rdata0 <= (w_complete && !r_op_wr) ? bus.s_rdata : '0;
            r_bus_err <= w_timeout;
         end
         if (r_state == BUSY && w_state_nxt == BUSY) begin
            if (r_wdog != '1) r_wdog <= r_wdog + 16'd1;
         end else begin
            r_wdog <= '0;
         end
      end
   end
endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed bench for mmio_bus_arbiter with the watchdog shortened to 4 BUSY cycles.
module tb_mmio_bus_arbiter;
   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;

   logic clk = 1'b0;
   logic rstn;
   int   errors = 0;
   int   checks = 0;

   mmio_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mmio_bus_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .TIMEOUT_CYC (4)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rstn = 1'b0;
      bus.m0_addr = '0; bus.m0_ren = 1'b0; bus.m0_wen = 1'b0; bus.m0_wdata = '0; bus.m0_wmask = '0;
      bus.m1_addr = '0; bus.m1_ren = 1'b0; bus.m1_wen = 1'b0; bus.m1_wdata = '0; bus.m1_wmask = '0;
      bus.s_rdata = '0; bus.s_rvalid = 1'b0; bus.s_wvalid = 1'b0;
      bus.m0_ren = 1'b1;

      // reset state; stall follows the request even in reset
      tick(); #1;
      chk("rst_grant",   64'(bus.grant),    64'd0);
      chk("rst_s_ren",   64'(bus.s_ren),    64'd0);
      chk("rst_s_wen",   64'(bus.s_wen),    64'd0);
      chk("rst_bus_err", 64'(bus.bus_err),  64'd0);
      chk("rst_m0_rd",   bus.m0_rdata,      64'd0);
      chk("rst_m0_stall",64'(bus.m0_stall), 64'd1);
      chk("rst_m1_stall",64'(bus.m1_stall), 64'd0);
      tick(); rstn = 1'b1; bus.m0_ren = 1'b0;

      // 1: m0 read, rvalid in third BUSY cycle
      tick(); bus.m0_ren = 1'b1; bus.m0_addr = 64'h8000_0000; #1;
      chk("t1_idle_grant", 64'(bus.grant),    64'd0);
      chk("t1_idle_stall", 64'(bus.m0_stall), 64'd1);
      tick(); #1;
      chk("t1_b1_sren",  64'(bus.s_ren),    64'd1);
      chk("t1_b1_raddr", bus.s_raddr,       64'h8000_0000);
      chk("t1_b1_grant", 64'(bus.grant),    64'd1);
      chk("t1_b1_stall", 64'(bus.m0_stall), 64'd1);
      tick(); #1;
      chk("t1_b2_sren",  64'(bus.s_ren),    64'd1);
      tick(); bus.s_rvalid = 1'b1; bus.s_rdata = 64'hDEAD_BEEF; #1;
      chk("t1_b3_sren",  64'(bus.s_ren),    64'd1);
      chk("t1_b3_stall", 64'(bus.m0_stall), 64'd1);
      tick(); bus.s_rvalid = 1'b0; bus.s_rdata = '0; #1;
      chk("t1_done_stall", 64'(bus.m0_stall), 64'd0);
      chk("t1_done_rdata", bus.m0_rdata,      64'hDEAD_BEEF);
      chk("t1_done_sren",  64'(bus.s_ren),    64'd0);
      chk("t1_done_grant", 64'(bus.grant),    64'd1);
      tick(); bus.m0_ren = 1'b0; #1;
      chk("t1_idle2_grant", 64'(bus.grant), 64'd0);

      // 2: contention after reset: m0, then m1, then m0 again (it re-requested)
      tick(); rstn = 1'b0;
      tick(); rstn = 1'b1;
      tick(); bus.m0_ren = 1'b1; bus.m0_addr = 64'h100; bus.m1_ren = 1'b1; bus.m1_addr = 64'h200; #1;
      chk("t2_idle_grant", 64'(bus.grant), 64'd0);
      tick(); bus.s_rvalid = 1'b1; bus.s_rdata = 64'h1111; #1;
      chk("t2_a_grant", 64'(bus.grant), 64'd1);
      chk("t2_a_raddr", bus.s_raddr,    64'h100);
      tick(); bus.s_rvalid = 1'b0; #1;
      chk("t2_a_m0stall", 64'(bus.m0_stall), 64'd0);
      chk("t2_a_m1stall", 64'(bus.m1_stall), 64'd1);
      chk("t2_a_rdata",   bus.m0_rdata,      64'h1111);
      tick(); bus.m0_addr = 64'h300; #1;
      chk("t2_turn_grant",   64'(bus.grant),    64'd0);
      chk("t2_turn_m0stall", 64'(bus.m0_stall), 64'd1);
      tick(); bus.s_rvalid = 1'b1; bus.s_rdata = 64'h2222; #1;
      chk("t2_b_grant", 64'(bus.grant), 64'd2);
      chk("t2_b_raddr", bus.s_raddr,    64'h200);
      tick(); bus.s_rvalid = 1'b0; #1;
      chk("t2_b_m1stall", 64'(bus.m1_stall), 64'd0);
      chk("t2_b_m0stall", 64'(bus.m0_stall), 64'd1);
      chk("t2_b_rdata",   bus.m1_rdata,      64'h2222);
      tick(); bus.m1_ren = 1'b0; #1;
      chk("t2_turn2_grant", 64'(bus.grant), 64'd0);
      tick(); bus.s_rvalid = 1'b1; bus.s_rdata = 64'h3333; #1;
      chk("t2_c_grant", 64'(bus.grant), 64'd1);
      chk("t2_c_raddr", bus.s_raddr,    64'h300);
      tick(); bus.s_rvalid = 1'b0; #1;
      chk("t2_c_rdata", bus.m0_rdata,      64'h3333);
      chk("t2_c_stall", 64'(bus.m0_stall), 64'd0);
      tick(); bus.m0_ren = 1'b0;

      // 3: m1 write completing in its first BUSY cycle
      tick(); bus.m1_wen = 1'b1; bus.m1_addr = 64'h1000_0008;
      bus.m1_wdata = 64'h1122_3344_5566_7788; bus.m1_wmask = 8'h0F; #1;
      chk("t3_idle_swen", 64'(bus.s_wen), 64'd0);
      tick(); bus.s_wvalid = 1'b1; #1;
      chk("t3_swen",  64'(bus.s_wen),    64'd1);
      chk("t3_sren",  64'(bus.s_ren),    64'd0);
      chk("t3_waddr", bus.s_waddr,       64'h1000_0008);
      chk("t3_wdata", bus.s_wdata,       64'h1122_3344_5566_7788);
      chk("t3_wmask", 64'(bus.s_wmask),  64'h0F);
      chk("t3_grant", 64'(bus.grant),    64'd2);
      chk("t3_stall", 64'(bus.m1_stall), 64'd1);
      tick(); bus.s_wvalid = 1'b0; #1;
      chk("t3_done_swen",  64'(bus.s_wen),    64'd0);
      chk("t3_done_stall", 64'(bus.m1_stall), 64'd0);
      tick(); bus.m1_wen = 1'b0;

      // 4: read never completes (stray wvalid must not end it); watchdog aborts after 4 BUSY cycles
      tick(); bus.m0_ren = 1'b1; bus.m0_addr = 64'h400; bus.s_wvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(); #1;
         chk("t4_busy_sren", 64'(bus.s_ren),   64'd1);
         chk("t4_busy_err",  64'(bus.bus_err), 64'd0);
      end
      tick(); #1;
      chk("t4_done_err",   64'(bus.bus_err),  64'd1);
      chk("t4_done_rdata", bus.m0_rdata,      64'd0);
      chk("t4_done_stall", 64'(bus.m0_stall), 64'd0);
      chk("t4_done_sren",  64'(bus.s_ren),    64'd0);
      tick(); bus.s_wvalid = 1'b0; bus.m0_addr = 64'h500; #1;
      chk("t4_idle_err",   64'(bus.bus_err), 64'd0);
      chk("t4_idle_grant", 64'(bus.grant),   64'd0);
      tick(); #1;
      chk("t4_retry_raddr", bus.s_raddr,    64'h500);
      chk("t4_retry_b1",    64'(bus.s_ren), 64'd1);
      tick(); bus.s_rvalid = 1'b1; bus.s_rdata = 64'h4444; #1;
      chk("t4_retry_b2",    64'(bus.s_ren), 64'd1);
      tick(); bus.s_rvalid = 1'b0; #1;
      chk("t4_retry_rdata", bus.m0_rdata,      64'h4444);
      chk("t4_retry_err",   64'(bus.bus_err),  64'd0);
      tick(); bus.m0_ren = 1'b0;

      // 5: reset in the middle of an m0 write; rr pointer returns to m0
      tick(); bus.m0_wen = 1'b1; bus.m0_addr = 64'h600; bus.m0_wdata = 64'hAA; bus.m0_wmask = 8'hFF;
      tick(); #1;
      chk("t5_busy_swen",  64'(bus.s_wen), 64'd1);
      chk("t5_busy_grant", 64'(bus.grant), 64'd1);
      #2; rstn = 1'b0; #1;
      chk("t5_rst_swen",    64'(bus.s_wen),    64'd0);
      chk("t5_rst_sren",    64'(bus.s_ren),    64'd0);
      chk("t5_rst_grant",   64'(bus.grant),    64'd0);
      chk("t5_rst_m0stall", 64'(bus.m0_stall), 64'd1);
      chk("t5_rst_m0rdata", bus.m0_rdata,      64'd0);
      bus.m1_ren = 1'b1; bus.m1_addr = 64'h700;
      tick(); rstn = 1'b1; #1;
      chk("t5_rel_grant", 64'(bus.grant), 64'd0);
      chk("t5_rel_swen",  64'(bus.s_wen), 64'd0);
      tick(); bus.s_wvalid = 1'b1; #1;
      chk("t5_re_grant", 64'(bus.grant), 64'd1);
      chk("t5_re_swen",  64'(bus.s_wen), 64'd1);
      chk("t5_re_waddr", bus.s_waddr,    64'h600);
      tick(); bus.s_wvalid = 1'b0; #1;
      chk("t5_re_m0stall", 64'(bus.m0_stall), 64'd0);
      chk("t5_re_m1stall", 64'(bus.m1_stall), 64'd1);
      tick(); bus.m0_wen = 1'b0; #1;
      chk("t5_turn_grant", 64'(bus.grant), 64'd0);
      tick(); bus.s_rvalid = 1'b1; bus.s_rdata = 64'h5555; #1;
      chk("t5_m1_grant", 64'(bus.grant), 64'd2);
      chk("t5_m1_raddr", bus.s_raddr,    64'h700);
      tick(); bus.s_rvalid = 1'b0; #1;
      chk("t5_m1_rdata", bus.m1_rdata, 64'h5555);
      tick(); bus.m1_ren = 1'b0;

      // 6: ren&wen on m1 is a write; rvalid alone does not finish it; rdata returns 0
      tick(); bus.m1_ren = 1'b1; bus.m1_wen = 1'b1; bus.m1_addr = 64'h800;
      bus.m1_wdata = 64'h99; bus.m1_wmask = 8'h03;
      tick(); bus.s_rvalid = 1'b1; bus.s_rdata = 64'hBAD; #1;
      chk("t6_b1_swen", 64'(bus.s_wen), 64'd1);
      chk("t6_b1_sren", 64'(bus.s_ren), 64'd0);
      tick(); bus.s_wvalid = 1'b1; #1;
      chk("t6_b2_swen", 64'(bus.s_wen), 64'd1);
      tick(); bus.s_rvalid = 1'b0; bus.s_wvalid = 1'b0; #1;
      chk("t6_done_rdata", bus.m1_rdata,      64'd0);
      chk("t6_done_stall", 64'(bus.m1_stall), 64'd0);
      tick(); bus.m1_ren = 1'b0; bus.m1_wen = 1'b0; #1;
      chk("t6_idle_grant", 64'(bus.grant), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
